fifo_ctrl: RTL and testbench

- Single-clock first-word-fall-through FIFO controller that sequences one dp_bram4096 dual-port block RAM.
- Owns the write/read pointers, occupancy and a valid/ready handshake on both sides.
- Hides the RAM's one-cycle registered read latency so a consumer sees head data with pop_valid and can pop one word per cycle.
- Sits between any byte/word producer (e.g. UART RX, bus master) and its consumer.

---
 rtl/fifo_pkg.sv | 19 +
 rtl/dp_bram4096.sv | 39 +++
 rtl/fifo_ctrl.sv | 120 ++++++++++++
 tb/tb_fifo_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared types and sizing helpers for the FIFO controller and the
// block RAM it sequences.
//   BRAM_BITS   : total bit capacity of one dp_bram4096
//   fifo_depth  : number of WIDTH-bit entries that fit in one BRAM
//   out_state_t : output-side state of the FIFO head register
package fifo_pkg;

    localparam int BRAM_BITS = 4096;

    function automatic int fifo_depth(input int width);
        return BRAM_BITS / width;
    endfunction

    typedef enum logic {
        EMPTY = 1'b0,
        VALID = 1'b1
    } out_state_t;

endpackage

// File: rtl/dp_bram4096.sv
// dp_bram4096: 4096-bit simple dual-port block RAM, one write port and one
// read port, each on its own clock. Reads are registered (one-cycle latency)
// and performed every cycle from addr_out.
//   clk_in   : write clock
//   en_in    : write enable
//   addr_in  : write address
//   data_in  : write data
//   clk_out  : read clock
//   addr_out : read address
//   data_out : registered read data
module dp_bram4096
    import fifo_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int DEPTH = fifo_depth(WIDTH),
    localparam int ADDRW = $clog2(DEPTH)
) (
    input  logic             clk_in,
    input  logic             en_in,
    input  logic [ADDRW-1:0] addr_in,
    input  logic [WIDTH-1:0] data_in,
    input  logic             clk_out,
    input  logic [ADDRW-1:0] addr_out,
    output logic [WIDTH-1:0] data_out
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk_in) begin
        if (en_in) begin
            mem[addr_in] <= data_in;
        end
    end

    always_ff @(posedge clk_out) begin
        data_out <= mem[addr_out];
    end

endmodule

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: single-clock first-word-fall-through FIFO built on one
// dp_bram4096. Hides the RAM's registered read so the head word is presented
// together with pop_valid.
//   clk        : clock, also drives both RAM ports
//   rst        : synchronous active-high reset
//   push_valid : producer offers push_data
//   push_data  : word to enqueue
//   push_ready : FIFO can accept a word (registered)
//   pop_valid  : head word present on pop_data
//   pop_data   : head word, straight from RAM data_out
//   pop_ready  : consumer takes the head word
//   count      : words held, issued head word included
//
// Output state machine
//   state | meaning
//   EMPTY | no head word on pop_data, pop_valid=0
//   VALID | head word on pop_data, pop_valid=1
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int DEPTH = fifo_depth(WIDTH),
    localparam int ADDRW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_valid,
    input  logic [WIDTH-1:0] push_data,
    output logic             push_ready,
    output logic             pop_valid,
    output logic [WIDTH-1:0] pop_data,
    input  logic             pop_ready,
    output logic [ADDRW:0]   count
);

    localparam logic [ADDRW:0] PTR_ONE   = (ADDRW+1)'(1);
    localparam logic [ADDRW:0] DEPTH_CNT = (ADDRW+1)'(DEPTH);

    out_state_t       state, state_next;
    logic [ADDRW:0]   wr_ptr, rd_ptr;
    logic [ADDRW:0]   count_next;
    logic [ADDRW-1:0] hold_addr;
    logic [ADDRW-1:0] rd_addr;
    logic             push_fire, pop_fire;
    logic             avail, issue;

    assign push_fire = push_valid & push_ready;
    assign pop_fire  = pop_valid & pop_ready;

    // wr_ptr is registered, so a word written this cycle is not yet visible
    // here; this keeps read and write addresses from ever colliding.
    assign avail = (wr_ptr != rd_ptr);
    assign issue = avail & (~pop_valid | pop_fire);

    // Re-reading the held address keeps pop_data steady through stalls. The
    // held slot cannot be overwritten because count still includes it.
    assign rd_addr = issue ? rd_ptr[ADDRW-1:0] : hold_addr;

    assign count_next = count + {{ADDRW{1'b0}}, push_fire}
                              - {{ADDRW{1'b0}}, pop_fire};

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= EMPTY;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            hold_addr  <= '0;
            count      <= '0;
            push_ready <= 1'b0;
        end else begin
            state      <= state_next;
            count      <= count_next;
            // Registered so pop_ready has no combinational path to push_ready;
            // a pop at full reopens the producer one cycle later.
            push_ready <= (count_next < DEPTH_CNT);
            if (push_fire) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (issue) begin
                rd_ptr    <= rd_ptr + PTR_ONE;
                hold_addr <= rd_ptr[ADDRW-1:0];
            end
        end
    end

    always_comb begin
        state_next = state;
        pop_valid  = 1'b0;
        unique case (state)
            EMPTY: begin
                pop_valid = 1'b0;
                if (issue) begin
                    state_next = VALID;
                end
            end
            VALID: begin
                pop_valid = 1'b1;
                if (pop_fire && !issue) begin
                    state_next = EMPTY;
                end
            end
            default: begin
                state_next = EMPTY;
            end
        endcase
    end

    dp_bram4096 #(
        .WIDTH(WIDTH)
    ) u_bram (
        .clk_in  (clk),
        .en_in   (push_fire),
        .addr_in (wr_ptr[ADDRW-1:0]),
        .data_in (push_data),
        .clk_out (clk),
        .addr_out(rd_addr),
        .data_out(pop_data)
    );

endmodule

// File: tb/tb_fifo_ctrl.sv
// Randomised bench for fifo_ctrl at WIDTH=8. A queue-based reference model
// tracks stored words and when each becomes visible at the head.
module tb_fifo_ctrl;

    localparam int WIDTH = 8;
    localparam int DEPTH = 512;
    localparam int ADDRW = 9;

    logic             clk;
    logic             rst;
    logic             push_valid;
    logic [WIDTH-1:0] push_data;
    logic             push_ready;
    logic             pop_valid;
    logic [WIDTH-1:0] pop_data;
    logic             pop_ready;
    logic [ADDRW:0]   count;

    fifo_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .push_valid(push_valid),
        .push_data (push_data),
        .push_ready(push_ready),
        .pop_valid (pop_valid),
        .pop_data  (pop_data),
        .pop_ready (pop_ready),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] d;
        int               pc;
    } ent_t;

    ent_t mq[$];
    int   cyc;
    int   last_pop;
    logic m_push_ready;
    logic fired;
    int   n_err;
    int   n_chk;
    logic [WIDTH-1:0] pend;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock cycle: check outputs of this cycle, drive this cycle's inputs,
    // then advance the model by the fires those inputs cause at the next edge.
    // A word pushed in cycle p is visible from max(p+2, previous pop + 1).
    task automatic cycle(input logic pv, input logic [WIDTH-1:0] pd,
                         input logic pr, input logic r);
        logic vis;
        int   t;
        @(negedge clk);
        cyc++;
        vis = 1'b0;
        if (mq.size() > 0) begin
            t = mq[0].pc + 2;
            if (last_pop + 1 > t) t = last_pop + 1;
            vis = (cyc >= t);
        end
        chk("push_ready", {31'd0, push_ready}, {31'd0, m_push_ready});
        chk("pop_valid", {31'd0, pop_valid}, {31'd0, vis});
        chk("count", {22'd0, count}, mq.size());
        if (vis) chk("pop_data", {24'd0, pop_data}, {24'd0, mq[0].d});
        push_valid = pv;
        push_data  = pd;
        pop_ready  = pr;
        rst        = r;
        if (r) begin
            mq.delete();
            m_push_ready = 1'b0;
            last_pop     = -100;
            fired        = 1'b0;
        end else begin
            fired = pv && m_push_ready;
            if (vis && pr) begin
                void'(mq.pop_front());
                last_pop = cyc;
            end
            if (fired) mq.push_back('{pd, cyc});
            m_push_ready = (mq.size() < DEPTH);
        end
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (mq.size() > 0 && n < budget) begin
            cycle(1'b0, 8'h00, 1'b1, 1'b0);
            n++;
        end
        chk("drain_done", mq.size(), 0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    initial begin
        int n_acc;
        int guard;
        int pv_pct;
        int pr_pct;
        n_err = 0; n_chk = 0; cyc = 0; last_pop = -100;
        m_push_ready = 1'b0; fired = 1'b0;
        rst = 1'b1; push_valid = 1'b1; push_data = 8'h11; pop_ready = 1'b0;

        // reset with push_valid high: nothing may be written
        cycle(1'b1, 8'h11, 1'b0, 1'b1);
        cycle(1'b1, 8'h11, 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        chk("ready_after_rst", {31'd0, push_ready}, 32'd1);

        // single word, held for many cycles, then popped
        cycle(1'b1, 8'hA5, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0);
        chk("single_held", {24'd0, pop_data}, 32'hA5);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        chk("single_empty", {22'd0, count}, 32'd0);

        // streaming 0..99 with the consumer always ready
        for (int i = 0; i < 100; i++) begin
            cycle(1'b1, 8'(i), 1'b1, 1'b0);
            chk("stream_cnt_le2", {31'd0, (count <= 2)}, 32'd1);
        end
        drain(20);

        // fill to full with the consumer stalled
        n_acc = 0; guard = 0;
        pend = 8'($urandom);
        while (n_acc < DEPTH && guard < 2000) begin
            cycle(1'b1, pend, 1'b0, 1'b0);
            if (fired) begin n_acc++; pend = 8'($urandom); end
            guard++;
        end
        for (int i = 0; i < 5; i++) cycle(1'b1, pend, 1'b0, 1'b0);
        chk("full_count", {22'd0, count}, DEPTH);
        chk("full_ready", {31'd0, push_ready}, 32'd0);
        cycle(1'b1, pend, 1'b1, 1'b0);
        if (fired) pend = 8'($urandom);
        cycle(1'b1, pend, 1'b0, 1'b0);
        if (fired) pend = 8'($urandom);

        // 1500 more words across the pointer wrap
        n_acc = 0; guard = 0;
        while (n_acc < 1500 && guard < 10000) begin
            cycle(1'b1, pend, ($urandom_range(99) < 70), 1'b0);
            if (fired) begin n_acc++; pend = 8'($urandom); end
            guard++;
        end
        chk("wrap_words", n_acc, 1500);
        drain(2000);

        // random backpressure on both sides
        n_acc = 0; guard = 0;
        pv_pct = 60; pr_pct = 60;
        pend = 8'($urandom);
        while (n_acc < 10000 && guard < 60000) begin
            if (guard % 500 == 0) begin
                pv_pct = $urandom_range(90, 30);
                pr_pct = $urandom_range(90, 30);
            end
            cycle(($urandom_range(99) < pv_pct), pend,
                  ($urandom_range(99) < pr_pct), 1'b0);
            if (fired) begin n_acc++; pend = 8'($urandom); end
            guard++;
        end
        chk("bp_words", n_acc, 10000);
        drain(2000);

        // mid-stream reset at 37 words, then one fresh word
        guard = 0;
        while (mq.size() < 37 && guard < 200) begin
            cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
            guard++;
        end
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        chk("mid_count", {22'd0, count}, 32'd37);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        chk("rst_count", {22'd0, count}, 32'd0);
        chk("rst_valid", {31'd0, pop_valid}, 32'd0);
        cycle(1'b1, 8'h3C, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        chk("post_rst_valid", {31'd0, pop_valid}, 32'd1);
        chk("post_rst_data", {24'd0, pop_data}, 32'h3C);
        drain(10);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
